// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared encodings and seed constants for the LED pattern sequencer.
package led_seq_pkg;
  typedef enum logic [1:0] {SHL = 2'd0, SHR = 2'd1, BOUNCE = 2'd2, BLINK = 2'd3} mode_e;
  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_e;
  typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} dir_e;
  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] SEED_SHIFT = 64'd1;
  localparam logic [MAX_W-1:0] SEED_BLINK = '1;
endpackage

// File: rtl/led_pattern_sequencer_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer plus rising-edge detect giving a one-cycle press pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  logic [2:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else sync_q <= {sync_q[1:0], btn_i};
  end
  assign press_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: prescaled, mode-selectable LED pattern engine driven by two push buttons.
import led_seq_pkg::*;
module led_pattern_sequencer #(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_run,
  output logic [WIDTH-1:0] led_out,
  output logic [1:0]       mode,
  output logic             running,
  output logic             step_pulse
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  logic mode_p, run_p, wrap, step, flip;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] led_q, step_led;
  mode_e mode_q, mode_n;
  state_e state_q;
  dir_e dir_q, step_dir;
  logic step_q;
  btn_sync_edge u_mode (.clk(clk), .rst(rst), .btn_i(btn_mode), .press_o(mode_p));
  btn_sync_edge u_run (.clk(clk), .rst(rst), .btn_i(btn_run), .press_o(run_p));
  // BOUNCE reverses when the lit bit has reached the end it is travelling toward
  always_comb begin
    wrap = state_q == RUN && cnt_q == CNT_MAX;
    step = wrap && !mode_p;
    mode_n = mode_e'(mode_q + 2'd1);
    flip = mode_q == BOUNCE && led_q != '0 && (dir_q == LEFT ? led_q[WIDTH-1] : led_q[0]);
    step_dir = flip ? dir_e'(~dir_q) : dir_q;
    step_led = mode_q == BLINK ? ~led_q :
               led_q == '0 ? SEED_SHIFT[WIDTH-1:0] :
               mode_q == SHL ? {led_q[WIDTH-2:0], led_q[WIDTH-1]} :
               mode_q == SHR ? {led_q[0], led_q[WIDTH-1:1]} :
               ((dir_q == LEFT) ^ flip) ? led_q << 1 : led_q >> 1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= SEED_SHIFT[WIDTH-1:0];
      mode_q  <= SHL;
      state_q <= PAUSE;
      dir_q   <= LEFT;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      step_q <= step;
      if (run_p) state_q <= state_q == RUN ? PAUSE : RUN;
      if (mode_p) begin
        mode_q <= mode_n;
        led_q  <= mode_n == BLINK ? SEED_BLINK[WIDTH-1:0] : SEED_SHIFT[WIDTH-1:0];
        dir_q  <= LEFT;
        cnt_q  <= '0;
      end else begin
        if (state_q == RUN) cnt_q <= wrap ? '0 : cnt_q + CW'(1);
        if (step) begin
          led_q <= step_led;
          dir_q <= step_dir;
        end
      end
    end
  end
  assign led_out    = led_q;
  assign mode       = mode_q;
  assign running    = state_q == RUN;
  assign step_pulse = step_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed vector table plus randomized buttons against a behavioural model.
module tb_led_pattern_sequencer;
  localparam int W = 4, TD = 4;
  logic clk = 0, rst = 1, btn_mode = 0, btn_run = 0;
  logic [W-1:0] led_out;
  logic [1:0] mode;
  logic running, step_pulse;
  int checks = 0, failures = 0;
  int m_led, m_mode, m_ph, m_bi;
  bit m_run, m_sp;
  bit [2:0] hm, hr;
  int bseq[6] = '{1, 2, 4, 8, 4, 2};
  typedef struct {bit r; bit bm; bit br; int n; int led; int md; bit run; bit sp;} vec_t;
  vec_t v[$];

  always #5 clk = ~clk;

  led_pattern_sequencer #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_run(btn_run),
    .led_out(led_out), .mode(mode), .running(running), .step_pulse(step_pulse)
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit mp, rp, st;
    @(posedge clk);
    if (rst) begin
      m_led = 1; m_mode = 0; m_run = 0; m_sp = 0; m_ph = 0; m_bi = 0; hm = 0; hr = 0;
    end else begin
      mp = hm[1] & ~hm[2];
      rp = hr[1] & ~hr[2];
      st = m_run && m_ph == TD - 1 && !mp;
      m_sp = st;
      if (mp) begin
        m_mode = (m_mode + 1) % 4;
        m_led = m_mode == 3 ? 15 : 1;
        m_bi = 0;
        m_ph = 0;
      end else begin
        if (m_run) m_ph = (m_ph + 1) % TD;
        if (st) begin
          case (m_mode)
            0: m_led = m_led == 0 ? 1 : ((m_led << 1) | (m_led >> 3)) & 15;
            1: m_led = m_led == 0 ? 1 : ((m_led >> 1) | (m_led << 3)) & 15;
            2: begin m_bi = (m_bi + 1) % 6; m_led = bseq[m_bi]; end
            default: m_led = m_led ^ 15;
          endcase
        end
      end
      m_run = m_run ^ rp;
      hm = {hm[1:0], btn_mode};
      hr = {hr[1:0], btn_run};
    end
    #1;
    chk("model_led", int'(led_out), m_led);
    chk("model_mode", int'(mode), m_mode);
    chk("model_running", int'(running), int'(m_run));
    chk("model_step_pulse", int'(step_pulse), int'(m_sp));
  endtask

  function automatic void add(bit r, bit bm, bit br, int n, int led, int md, bit run, bit sp);
    v.push_back('{r, bm, br, n, led, md, run, sp});
  endfunction

  initial begin
    add(1,0,0,2, 1,0,0,0); add(0,0,0,3, 1,0,0,0);
    add(0,0,1,1, 1,0,0,0); add(0,0,0,1, 1,0,0,0); add(0,0,0,1, 1,0,1,0);
    add(0,0,0,3, 1,0,1,0); add(0,0,0,1, 2,0,1,1);
    add(0,0,0,3, 2,0,1,0); add(0,0,0,1, 4,0,1,1);
    add(0,0,0,3, 4,0,1,0); add(0,0,0,1, 8,0,1,1);
    add(0,0,0,3, 8,0,1,0); add(0,0,0,1, 1,0,1,1);
    add(0,1,0,1, 1,0,1,0); add(0,0,0,1, 1,0,1,0); add(0,0,0,1, 1,1,1,0);
    add(0,0,0,3, 1,1,1,0); add(0,0,0,1, 8,1,1,1);
    add(0,0,0,3, 8,1,1,0); add(0,0,0,1, 4,1,1,1);
    add(0,1,0,1, 4,1,1,0); add(0,0,0,1, 4,1,1,0); add(0,0,0,1, 1,2,1,0);
    add(0,0,0,4, 2,2,1,1); add(0,0,0,4, 4,2,1,1); add(0,0,0,4, 8,2,1,1);
    add(0,0,0,4, 4,2,1,1); add(0,0,0,4, 2,2,1,1); add(0,0,0,4, 1,2,1,1);
    add(0,1,0,1, 1,2,1,0); add(0,0,0,2, 15,3,1,0);
    add(0,0,0,4, 0,3,1,1); add(0,0,0,4, 15,3,1,1); add(0,0,0,4, 0,3,1,1);
    add(0,1,0,1, 0,3,1,0); add(0,0,0,2, 1,0,1,0);
    add(0,0,1,1, 1,0,1,0); add(0,0,0,1, 1,0,1,0); add(0,0,0,1, 1,0,0,0);
    add(0,0,0,20, 1,0,0,0);
    add(0,0,1,1, 1,0,0,0); add(0,0,0,1, 1,0,0,0); add(0,0,0,1, 1,0,1,0);
    add(0,0,0,1, 2,0,1,1);
    add(0,0,0,1, 2,0,1,0); add(0,1,0,1, 2,0,1,0); add(0,0,0,1, 2,0,1,0);
    add(0,0,0,1, 1,1,1,0); add(0,0,0,3, 1,1,1,0); add(0,0,0,1, 8,1,1,1);
    add(0,1,0,10, 2,2,1,0); add(0,0,0,3, 4,2,1,0); add(0,0,0,6, 4,2,1,1);
    add(1,0,0,1, 1,0,0,0); add(0,0,0,2, 1,0,0,0);
    add(0,0,1,1, 1,0,0,0); add(0,0,0,1, 1,0,0,0); add(0,0,0,1, 1,0,1,0);
    add(0,0,0,3, 1,0,1,0); add(0,0,0,1, 2,0,1,1);
    for (int i = 0; i < v.size(); i++) begin
      rst = v[i].r; btn_mode = v[i].bm; btn_run = v[i].br;
      repeat (v[i].n) tick();
      chk($sformatf("vec%0d_led", i), int'(led_out), v[i].led);
      chk($sformatf("vec%0d_mode", i), int'(mode), v[i].md);
      chk($sformatf("vec%0d_running", i), int'(running), int'(v[i].run));
      chk($sformatf("vec%0d_step_pulse", i), int'(step_pulse), int'(v[i].sp));
    end
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 9) == 0) btn_run = ~btn_run;
      rst = $urandom_range(0, 299) == 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
